nkmd_dai_tx: RTL and testbench
==============================

// Module: nkmd_dai_tx
// PURPOSE
// - CPU-to-DAI sample path: nkmd core fills a 64-entry ring buffer through its memory-mapped data bus;
//   the downstream DAI serializer pops one 24-bit sample per ack. Mirror of nkmd_dai_rx on the nkmd bus.
// - CPU writes samples into a window relative to the write pointer, then commits one sample per write to
//   the control register; serializer drains from the read pointer. Underruns emit silence and are counted.
// PARAMETERS
// - DATA_W   24  sample width
// - PTR_W    6   ring pointer width; depth 2**PTR_W = 64, max queued = 63
// PORTS
// - clk        in   1       system clock
// - rst        in   1       asynchronous reset, active-high
// - tx_data_o  out  DATA_W  sample presented to DAI serializer (registered)
// - tx_ack_i   in   1       1-cycle pop request from serializer
// - data_i     in   32      nkmd write data
// - data_o     out  32      nkmd read data (registered, 1-cycle latency)
// - addr_i     in   32      nkmd address
// - we_i       in   1       nkmd write enable
// BEHAVIOUR
// - Reset: wptr=0, rptr=0, queued_ff=0, underrun_ff=0, tx_data_o=0, data_o=0. Ring RAM contents undefined.
// - Decode (addr_i[15:12], offset = addr_i[PTR_W-1:0]):
//   - 0xd000 R: {26'b0, queued_ff}.  W: commit -> wptr+1, queued_ff+1; data_i ignored.
//   - 0xd001 R: {24'b0, underrun_ff}. W: clear underrun_ff to 0.
//   - 0xf000+n R: {8'b0, ring[wptr+n]}. W: ring[wptr+n] <= data_i[23:0]; n wraps mod 64.
//   - Other addresses: read 0, writes ignored.
// - data_o: registered every cycle from addr_i of previous cycle; addr held 1 cycle -> data valid next cycle.
// - Pop: on tx_ack_i, if queued_ff>0 (value before this cycle's commit): tx_data_o <= ring[rptr], rptr+1,
//   queued_ff-1. If queued_ff==0: tx_data_o <= 0, underrun_ff+1 saturating at 8'hff. tx_data_o holds otherwise.
// - Pop latency: sample visible on tx_data_o the cycle after tx_ack_i.
// - Full: commit while queued_ff==63 (and no successful pop same cycle) ignored; wptr, queued_ff unchanged.
// - Simultaneous commit + successful pop: both pointers advance, queued_ff unchanged (legal even at 63).
// - Commit + pop with queued_ff==0: pop underruns (commit not yet visible), commit proceeds -> queued_ff=1.
// - Window write + commit same cycle impossible (single bus); window write to n=0 then commit is the normal
//   sequence. Window writes never disturb queued entries only if CPU keeps n < 64-queued; not checked.
// - Underrun clear and underrun same cycle: clear wins (result 0).
// - Pointers wrap 63->0 naturally (PTR_W-bit arithmetic).
// - Reset mid-operation: all state returns to reset values immediately (async); queued data discarded.
// STRUCTURE
// - nkmd_dai_pkg: address constants (DAI_TX_CTRL=0xd000, DAI_TX_UNDERRUN=0xd001, DAI_TX_RING=0xf000),
//   DATA_W/PTR_W defaults, shared with nkmd_dai_rx.
// - Sub-module nkmd_dai_ringbuf: 64xDATA_W RAM, one sync write port (bus), two async read ports
//   (bus window, pop). Pointer/count/decode logic stays in nkmd_dai_tx.
// TESTING
// - After reset: read 0xd000 -> 0; read 0xd001 -> 0; tx_data_o == 0.
// - Write 0xf000=0xcafebb, write 0xd000; read 0xd000 -> 1; pulse tx_ack_i -> next cycle tx_data_o=0xcafebb,
//   queued 0.
// - Write 0xf000..0xf004 = 0xbeef00..04, commit x5; read 0xd000 -> 5; 5 pops -> tx_data_o 0xbeef00..04 in order.
// - Pop with empty buffer x3 -> tx_data_o=0, 0xd001 reads 3; write 0xd001 -> reads 0; 300 underruns -> 0xff.
// - Fill 63 (value i at commit i), 64th commit ignored (queued stays 63); pop 59, commit 4 more -> queued 8;
//   drain yields 59..66, pointers wrapped correctly.
// - Commit and tx_ack_i same cycle at queued=63 -> queued stays 63; at queued=0 -> tx_data_o=0, underrun+1,
//   queued=1. Assert rst mid-fill -> queued 0, tx_data_o 0 without clock edge.

Source files
------------

// File: rtl/nkmd_dai_pkg.sv
// Shared constants and bus decode for the nkmd DAI sample paths (tx and rx).
// Address map, default widths and the decode helper used by the tx block.
package nkmd_dai_pkg;

   localparam int unsigned DAI_DATA_W = 24;
   localparam int unsigned DAI_PTR_W  = 6;

   localparam logic [15:0] DAI_TX_CTRL     = 16'hd000;
   localparam logic [15:0] DAI_TX_UNDERRUN = 16'hd001;
   localparam logic [15:0] DAI_TX_RING     = 16'hf000;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_CTRL,
      SEL_UNDERRUN,
      SEL_RING
   } bus_sel_e;

   // The ring window occupies the whole 0xf000 page; the offset is taken mod depth by the caller.
   function automatic bus_sel_e decode_tx(input logic [15:0] addr);
      if (addr[15:12] == DAI_TX_RING[15:12]) return SEL_RING;
      if (addr == DAI_TX_CTRL)               return SEL_CTRL;
      if (addr == DAI_TX_UNDERRUN)           return SEL_UNDERRUN;
      return SEL_NONE;
   endfunction

endpackage

// File: rtl/nkmd_dai_ringbuf.sv
// Sample ring storage: one synchronous write port, two asynchronous read ports.
// Contents are not reset.
module nkmd_dai_ringbuf #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned PTR_W  = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [PTR_W-1:0]  raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] mem [2**PTR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/nkmd_dai_tx.sv
// CPU-to-DAI transmit path: CPU fills a ring through a window relative to the write
// pointer and commits samples; the serializer pops one sample per ack, underruns emit silence.
module nkmd_dai_tx
   import nkmd_dai_pkg::*;
#(
   parameter int unsigned DATA_W = DAI_DATA_W,
   parameter int unsigned PTR_W  = DAI_PTR_W
) (
   input  logic              clk,
   input  logic              rst,
   output logic [DATA_W-1:0] tx_data_o,
   input  logic              tx_ack_i,
   input  logic [31:0]       data_i,
   output logic [31:0]       data_o,
   input  logic [31:0]       addr_i,
   input  logic              we_i
);

   localparam logic [PTR_W-1:0] QUEUED_MAX = '1;

   logic [PTR_W-1:0]  wptr_ff;
   logic [PTR_W-1:0]  rptr_ff;
   logic [PTR_W-1:0]  queued_ff;
   logic [7:0]        underrun_ff;

   bus_sel_e          sel;
   logic [PTR_W-1:0]  win_addr;
   logic [DATA_W-1:0] win_data;
   logic [DATA_W-1:0] pop_data;
   logic              win_we;
   logic              commit;
   logic              commit_ok;
   logic              pop_ok;
   logic              pop_empty;
   logic              ur_clr;
   logic [31:0]       rd_data;
   logic              unused_bits;

   assign unused_bits = ^{addr_i[31:16], data_i[31:DATA_W]};

   always_comb begin
      sel       = decode_tx(addr_i[15:0]);
      win_addr  = wptr_ff + addr_i[PTR_W-1:0];
      win_we    = we_i && (sel == SEL_RING);
      commit    = we_i && (sel == SEL_CTRL);
      ur_clr    = we_i && (sel == SEL_UNDERRUN);
      pop_ok    = tx_ack_i && (queued_ff != '0);
      pop_empty = tx_ack_i && (queued_ff == '0);
      // A pop in the same cycle frees a slot, so a commit at full is still accepted.
      commit_ok = commit && ((queued_ff != QUEUED_MAX) || pop_ok);
   end

   always_comb begin
      rd_data = '0;
      case (sel)
         SEL_CTRL:     rd_data[PTR_W-1:0]  = queued_ff;
         SEL_UNDERRUN: rd_data[7:0]        = underrun_ff;
         SEL_RING:     rd_data[DATA_W-1:0] = win_data;
         default:      rd_data             = '0;
      endcase
   end

   nkmd_dai_ringbuf #(
      .DATA_W (DATA_W),
      .PTR_W  (PTR_W)
   ) u_ring (
      .clk     (clk),
      .we      (win_we),
      .waddr   (win_addr),
      .wdata   (data_i[DATA_W-1:0]),
      .raddr_a (win_addr),
      .rdata_a (win_data),
      .raddr_b (rptr_ff),
      .rdata_b (pop_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_ff     <= '0;
         rptr_ff     <= '0;
         queued_ff   <= '0;
         underrun_ff <= '0;
         tx_data_o   <= '0;
         data_o      <= '0;
      end else begin
         data_o <= rd_data;

         if (commit_ok) wptr_ff <= wptr_ff + PTR_W'(1);

         if (pop_ok) begin
            rptr_ff   <= rptr_ff + PTR_W'(1);
            tx_data_o <= pop_data;
         end else if (pop_empty) begin
            tx_data_o <= '0;
         end

         if (commit_ok && !pop_ok)      queued_ff <= queued_ff + PTR_W'(1);
         else if (!commit_ok && pop_ok) queued_ff <= queued_ff - PTR_W'(1);

         if (ur_clr)                                   underrun_ff <= '0;
         else if (pop_empty && (underrun_ff != 8'hff)) underrun_ff <= underrun_ff + 8'd1;
      end
   end

endmodule

// File: tb/tb_nkmd_dai_tx.sv
// Self-checking bench for nkmd_dai_tx: directed scenarios plus randomized bus/ack traffic
// checked against a queue-based model of the sample FIFO.
module tb_nkmd_dai_tx;

   localparam logic [31:0] A_CTRL = 32'h0000_d000;
   localparam logic [31:0] A_UND  = 32'h0000_d001;
   localparam logic [31:0] A_RING = 32'h0000_f000;
   localparam logic [31:0] A_NONE = 32'h0000_1234;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] tx_data_o;
   logic        tx_ack_i = 1'b0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic [31:0] addr_i = '0;
   logic        we_i = 1'b0;

   int checks = 0;
   int failures = 0;

   // Model: staged window contents by absolute slot, FIFO of committed samples.
   logic [23:0] ring [64];
   logic [23:0] fifo [$];
   int          wpos = 0;
   int          und = 0;
   logic [23:0] exp_tx = '0;
   logic [31:0] exp_rd = '0;

   nkmd_dai_tx #(.DATA_W(24), .PTR_W(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_data_o (tx_data_o),
      .tx_ack_i  (tx_ack_i),
      .data_i    (data_i),
      .data_o    (data_o),
      .addr_i    (addr_i),
      .we_i      (we_i)
   );

   always #5 clk = ~clk;

   task automatic cycle(input logic we, input logic [31:0] addr, input logic [31:0] din, input logic ack);
      logic is_ctrl, is_und, is_ring;
      @(negedge clk);
      we_i = we; addr_i = addr; data_i = din; tx_ack_i = ack;
      is_ctrl = (addr[15:0] == 16'hd000);
      is_und  = (addr[15:0] == 16'hd001);
      is_ring = (addr[15:12] == 4'hf);
      if (is_ctrl)      exp_rd = 32'(fifo.size());
      else if (is_und)  exp_rd = 32'(und);
      else if (is_ring) exp_rd = {8'h0, ring[(wpos + int'(addr[5:0])) % 64]};
      else              exp_rd = '0;
      // Pop sees the count before this cycle's commit, so apply it first.
      if (ack) begin
         if (fifo.size() > 0) exp_tx = fifo.pop_front();
         else begin
            exp_tx = '0;
            if (!(we && is_und) && und < 255) und++;
         end
      end
      if (we && is_und) und = 0;
      if (we && is_ring) ring[(wpos + int'(addr[5:0])) % 64] = din[23:0];
      if (we && is_ctrl && fifo.size() < 63) begin
         fifo.push_back(ring[wpos]);
         wpos = (wpos + 1) % 64;
      end
      @(posedge clk);
      #1;
      we_i = 1'b0; tx_ack_i = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] din);
      cycle(1'b1, addr, din, 1'b0);
   endtask

   task automatic rd(input logic [31:0] addr);
      cycle(1'b0, addr, 32'h0, 1'b0);
   endtask

   task automatic ack();
      cycle(1'b0, A_NONE, 32'h0, 1'b1);
   endtask

   task automatic model_reset();
      fifo.delete();
      wpos = 0;
      und = 0;
      exp_tx = '0;
      exp_rd = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (tx_data_o !== 24'h0) begin failures++; $display("FAIL reset_tx got=%h exp=%h", tx_data_o, 24'h0); end
      checks++;
      if (data_o !== 32'h0) begin failures++; $display("FAIL reset_data_o got=%h exp=%h", data_o, 32'h0); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      rd(A_CTRL);
      checks++;
      if (data_o !== 32'h0) begin failures++; $display("FAIL reset_queued got=%h exp=%h", data_o, 32'h0); end
      rd(A_UND);
      checks++;
      if (data_o !== 32'h0) begin failures++; $display("FAIL reset_underrun got=%h exp=%h", data_o, 32'h0); end
   endtask

   task automatic test_single();
      wr(A_RING, 32'h00ca_febb);
      wr(A_CTRL, 32'hffff_ffff);
      rd(A_CTRL);
      checks++;
      if (data_o !== 32'd1) begin failures++; $display("FAIL single_queued got=%h exp=%h", data_o, 32'd1); end
      ack();
      checks++;
      if (tx_data_o !== 24'hcafebb) begin failures++; $display("FAIL single_pop got=%h exp=%h", tx_data_o, 24'hcafebb); end
      rd(A_CTRL);
      checks++;
      if (data_o !== 32'd0) begin failures++; $display("FAIL single_drained got=%h exp=%h", data_o, 32'd0); end
   endtask

   task automatic test_burst();
      for (int i = 0; i < 5; i++) wr(A_RING + 32'(i), 32'h00be_ef00 + 32'(i));
      repeat (5) wr(A_CTRL, 32'h0);
      rd(A_CTRL);
      checks++;
      if (data_o !== 32'd5) begin failures++; $display("FAIL burst_queued got=%h exp=%h", data_o, 32'd5); end
      for (int i = 0; i < 5; i++) begin
         ack();
         checks++;
         if (tx_data_o !== 24'hbeef00 + 24'(i)) begin
            failures++; $display("FAIL burst_pop%0d got=%h exp=%h", i, tx_data_o, 24'hbeef00 + 24'(i));
         end
      end
   endtask

   task automatic test_underrun();
      for (int i = 0; i < 3; i++) begin
         ack();
         checks++;
         if (tx_data_o !== 24'h0) begin failures++; $display("FAIL underrun_silence%0d got=%h exp=%h", i, tx_data_o, 24'h0); end
      end
      rd(A_UND);
      checks++;
      if (data_o !== 32'd3) begin failures++; $display("FAIL underrun_count got=%h exp=%h", data_o, 32'd3); end
      wr(A_UND, 32'h0);
      rd(A_UND);
      checks++;
      if (data_o !== 32'd0) begin failures++; $display("FAIL underrun_clear got=%h exp=%h", data_o, 32'd0); end
      repeat (300) ack();
      rd(A_UND);
      checks++;
      if (data_o !== 32'hff) begin failures++; $display("FAIL underrun_saturate got=%h exp=%h", data_o, 32'hff); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 64; i++) begin
         wr(A_RING, 32'(i));
         wr(A_CTRL, 32'h0);
      end
      rd(A_CTRL);
      checks++;
      if (data_o !== 32'd63) begin failures++; $display("FAIL full_queued got=%h exp=%h", data_o, 32'd63); end
      for (int i = 0; i < 59; i++) begin
         ack();
         checks++;
         if (tx_data_o !== 24'(i)) begin failures++; $display("FAIL full_pop%0d got=%h exp=%h", i, tx_data_o, 24'(i)); end
      end
      for (int i = 63; i < 67; i++) begin
         wr(A_RING, 32'(i));
         wr(A_CTRL, 32'h0);
      end
      rd(A_CTRL);
      checks++;
      if (data_o !== 32'd8) begin failures++; $display("FAIL full_refill got=%h exp=%h", data_o, 32'd8); end
      for (int i = 0; i < 8; i++) begin
         ack();
         checks++;
         if (tx_data_o !== 24'(59 + i)) begin failures++; $display("FAIL wrap_pop%0d got=%h exp=%h", i, tx_data_o, 24'(59 + i)); end
      end
      rd(A_CTRL);
      checks++;
      if (data_o !== 32'd0) begin failures++; $display("FAIL wrap_drained got=%h exp=%h", data_o, 32'd0); end
   endtask

   task automatic test_simultaneous();
      wr(A_UND, 32'h0);
      for (int i = 0; i < 63; i++) begin
         wr(A_RING, 32'h100 + 32'(i));
         wr(A_CTRL, 32'h0);
      end
      wr(A_RING, 32'h777);
      cycle(1'b1, A_CTRL, 32'h0, 1'b1);
      checks++;
      if (tx_data_o !== 24'h100) begin failures++; $display("FAIL simul_full_pop got=%h exp=%h", tx_data_o, 24'h100); end
      rd(A_CTRL);
      checks++;
      if (data_o !== 32'd63) begin failures++; $display("FAIL simul_full_queued got=%h exp=%h", data_o, 32'd63); end
      repeat (62) ack();
      ack();
      checks++;
      if (tx_data_o !== 24'h777) begin failures++; $display("FAIL simul_last_pop got=%h exp=%h", tx_data_o, 24'h777); end
      wr(A_RING, 32'h555);
      cycle(1'b1, A_CTRL, 32'h0, 1'b1);
      checks++;
      if (tx_data_o !== 24'h0) begin failures++; $display("FAIL simul_empty_tx got=%h exp=%h", tx_data_o, 24'h0); end
      rd(A_CTRL);
      checks++;
      if (data_o !== 32'd1) begin failures++; $display("FAIL simul_empty_queued got=%h exp=%h", data_o, 32'd1); end
      rd(A_UND);
      checks++;
      if (data_o !== 32'd1) begin failures++; $display("FAIL simul_empty_underrun got=%h exp=%h", data_o, 32'd1); end
      // Underrun and clear together: clear wins.
      ack();
      cycle(1'b1, A_UND, 32'h0, 1'b1);
      rd(A_UND);
      checks++;
      if (data_o !== 32'd0) begin failures++; $display("FAIL clear_beats_underrun got=%h exp=%h", data_o, 32'd0); end
   endtask

   task automatic test_random();
      int unsigned op;
      logic [31:0] a;
      for (int c = 0; c < 600; c++) begin
         op = $urandom_range(0, 9);
         case (op)
            0, 1, 2: begin
               a = A_RING + 32'($urandom_range(0, 63 - fifo.size()));
               cycle(1'b1, a, $urandom, $urandom_range(0, 2) == 0);
            end
            3, 4:    cycle(1'b1, A_CTRL, $urandom, $urandom_range(0, 2) == 0);
            5:       cycle(1'b0, A_CTRL, 32'h0, $urandom_range(0, 1) == 0);
            6:       cycle(1'b0, A_UND, 32'h0, $urandom_range(0, 1) == 0);
            7:       cycle(1'b0, A_RING + 32'($urandom_range(0, 63)), 32'h0, $urandom_range(0, 1) == 0);
            8:       cycle($urandom_range(0, 3) == 0, A_UND, 32'h0, 1'b1);
            default: cycle($urandom_range(0, 1) == 0, A_NONE, $urandom, $urandom_range(0, 1) == 0);
         endcase
         checks++;
         if (data_o !== exp_rd) begin failures++; $display("FAIL rand_data_o c=%0d got=%h exp=%h", c, data_o, exp_rd); end
         checks++;
         if (tx_data_o !== exp_tx) begin failures++; $display("FAIL rand_tx c=%0d got=%h exp=%h", c, tx_data_o, exp_tx); end
      end
   endtask

   task automatic test_async_reset();
      wr(A_RING, 32'h00ab_cdef);
      wr(A_CTRL, 32'h0);
      ack();
      for (int i = 0; i < 4; i++) begin
         wr(A_RING, 32'h10 + 32'(i));
         wr(A_CTRL, 32'h0);
      end
      rd(A_CTRL);
      checks++;
      if (data_o !== exp_rd || tx_data_o !== exp_tx) begin
         failures++; $display("FAIL prereset_state got=%h/%h exp=%h/%h", data_o, tx_data_o, exp_rd, exp_tx);
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (tx_data_o !== 24'h0) begin failures++; $display("FAIL async_rst_tx got=%h exp=%h", tx_data_o, 24'h0); end
      checks++;
      if (data_o !== 32'h0) begin failures++; $display("FAIL async_rst_data_o got=%h exp=%h", data_o, 32'h0); end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      rd(A_CTRL);
      checks++;
      if (data_o !== 32'd0) begin failures++; $display("FAIL async_rst_queued got=%h exp=%h", data_o, 32'd0); end
      ack();
      checks++;
      if (tx_data_o !== 24'h0) begin failures++; $display("FAIL async_rst_empty_pop got=%h exp=%h", tx_data_o, 24'h0); end
      rd(A_UND);
      checks++;
      if (data_o !== 32'd1) begin failures++; $display("FAIL async_rst_underrun got=%h exp=%h", data_o, 32'd1); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ring[i] = '0;
      test_reset();
      test_single();
      test_burst();
      test_underrun();
      test_full();
      test_simultaneous();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
